// File: rtl/uart_rx_fifo_if.sv
// Line-side and consumer-side signal bundle for uart_rx_fifo.
// The design uses the slave modport; the producer/consumer side uses master.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                        rx;
    logic                        b_tick;
    logic                        rd_en;
    logic [DATA_BITS-1:0]        rd_data;
    logic                        rd_perr;
    logic                        rd_ferr;
    logic                        empty;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        overrun;
    logic                        break_det;

    modport master (
        output rx, b_tick, rd_en,
        input  rd_data, rd_perr, rd_ferr, empty, full, level, overrun, break_det
    );

    modport slave (
        input  rx, b_tick, rd_en,
        output rd_data, rd_perr, rd_ferr, empty, full, level, overrun, break_det
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data/parity/stop format, per-frame error flags) feeding a FWFT FIFO.
// Break detection with the BRK_WAIT state is built only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 32'sd1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = DATA_BITS + 32'sd2;

    localparam logic [TICK_W-1:0]    TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0]    TICK_ONE  = TICK_W'(1'b1);
    localparam logic [TICK_W-1:0]    TICK_HALF = TICK_W'(OVERSAMPLE / 32'sd2 - 32'sd1);
    localparam logic [TICK_W-1:0]    TICK_FULL = TICK_W'(OVERSAMPLE - 32'sd1);
    localparam logic [BIT_W-1:0]     BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]     BIT_ONE   = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0]     LAST_DATA = BIT_W'(DATA_BITS - 32'sd1);
    localparam logic [BIT_W-1:0]     LAST_STOP = BIT_W'(STOP_BITS - 32'sd1);
    localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]      LVL_ZERO  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]      LVL_ONE   = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0]      LVL_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};
    localparam logic                 HAS_PARITY = (PARITY != 32'sd0);
    localparam logic                 ODD_PARITY = (PARITY == 32'sd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
        , ST_BRK_WAIT = 3'd5
`endif
    } state_t;

    // Odd parity expects an odd count of ones across data plus parity bit.
    function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic pbit);
        return ((^d) ^ pbit) != ODD_PARITY;
    endfunction

    state_t               state_r, state_s;
    logic                 rx_meta_r, rx_sync_r, rx_s;
    logic [TICK_W-1:0]    tick_r, tick_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 perr_r, perr_s, ferr_r, ferr_s;
    logic                 half_s, centre_s, push_s, brk_s;
    logic [ENT_W-1:0]     mem_r [FIFO_DEPTH];
    logic [ENT_W-1:0]     head_s;
    logic [ADDR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [ADDR_W:0]      level_r, level_s;
    logic                 empty_r, full_r, overrun_r, pop_s, wr_s;
`ifdef UART_RX_BREAK_DET_EN
    logic                 par_bit_r, par_bit_s, brk_hit_s, break_r;
`endif

    assign rx_s     = rx_sync_r;
    assign half_s   = bus.b_tick && (tick_r == TICK_HALF);
    assign centre_s = bus.b_tick && (tick_r == TICK_FULL);

    // Two-flop synchroniser for the asynchronous rx pin, idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver state register and frame-assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            data_r  <= DATA_ZERO;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_r <= 1'b0;
            break_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            perr_r  <= perr_s;
            ferr_r  <= ferr_s;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_r <= par_bit_s;
            break_r   <= brk_s;
`endif
        end
    end

    // Next-state logic; the last stop-bit sample pushes and returns to IDLE at once.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        bit_s   = bit_r;
        data_s  = data_r;
        perr_s  = perr_r;
        ferr_s  = ferr_r;
        push_s  = 1'b0;
        brk_s   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_s = par_bit_r;
        brk_hit_s = (bit_r == BIT_ZERO) && (data_r == DATA_ZERO) && !par_bit_r && !rx_s;
`endif
        case (state_r)
            ST_IDLE: begin
                tick_s = TICK_ZERO;
                bit_s  = BIT_ZERO;
                perr_s = 1'b0;
                ferr_s = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                par_bit_s = 1'b0;
`endif
                if (!rx_s) state_s = ST_START;
                else       state_s = ST_IDLE;
            end
            ST_START: begin
                if (half_s) begin
                    tick_s = TICK_ZERO;
                    if (!rx_s) state_s = ST_DATA;
                    else       state_s = ST_IDLE;
                end else if (bus.b_tick) begin
                    tick_s = tick_r + TICK_ONE;
                end else begin
                    tick_s = tick_r;
                end
            end
            ST_DATA: begin
                if (centre_s) begin
                    tick_s = TICK_ZERO;
                    data_s = {rx_s, data_r[DATA_BITS-1:1]};
                    if (bit_r == LAST_DATA) begin
                        bit_s   = BIT_ZERO;
                        state_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else if (bus.b_tick) begin
                    tick_s = tick_r + TICK_ONE;
                end else begin
                    tick_s = tick_r;
                end
            end
            ST_PARITY: begin
                if (centre_s) begin
                    tick_s  = TICK_ZERO;
                    perr_s  = parity_err(data_r, rx_s);
                    state_s = ST_STOP;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_s = rx_s;
`endif
                end else if (bus.b_tick) begin
                    tick_s = tick_r + TICK_ONE;
                end else begin
                    tick_s = tick_r;
                end
            end
            ST_STOP: begin
                if (centre_s) begin
                    tick_s = TICK_ZERO;
`ifdef UART_RX_BREAK_DET_EN
                    if (brk_hit_s) begin
                        brk_s   = 1'b1;
                        bit_s   = BIT_ZERO;
                        state_s = ST_BRK_WAIT;
                    end else begin
`else
                    begin
`endif
                        ferr_s = ferr_r | ~rx_s;
                        if (bit_r == LAST_STOP) begin
                            push_s  = 1'b1;
                            bit_s   = BIT_ZERO;
                            state_s = ST_IDLE;
                        end else begin
                            bit_s = bit_r + BIT_ONE;
                        end
                    end
                end else if (bus.b_tick) begin
                    tick_s = tick_r + TICK_ONE;
                end else begin
                    tick_s = tick_r;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BRK_WAIT: begin
                if (rx_s) state_s = ST_IDLE;
                else      state_s = ST_BRK_WAIT;
            end
`endif
            default: begin
                state_s = ST_IDLE;
                tick_s  = TICK_ZERO;
                bit_s   = BIT_ZERO;
            end
        endcase
    end

    // When full, a same-cycle pop frees the slot so the push is still accepted.
    always_comb begin
        pop_s = bus.rd_en && !empty_r;
        wr_s  = push_s && (!full_r || pop_s);
        case ({wr_s, pop_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase
    end

    // FIFO storage, pointers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
            wr_ptr_r  <= ADDR_ZERO;
            rd_ptr_r  <= ADDR_ZERO;
            level_r   <= LVL_ZERO;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= {perr_r, ferr_s, data_r};
                wr_ptr_r        <= wr_ptr_r + ADDR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_ONE;
            end
            level_r   <= level_s;
            empty_r   <= (level_s == LVL_ZERO);
            full_r    <= (level_s == LVL_FULL);
            overrun_r <= push_s && !wr_s;
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign bus.rd_data = head_s[DATA_BITS-1:0];
    assign bus.rd_ferr = head_s[DATA_BITS];
    assign bus.rd_perr = head_s[DATA_BITS+1];
    assign bus.empty   = empty_r;
    assign bus.full    = full_r;
    assign bus.level   = level_r;
    assign bus.overrun = overrun_r;
`ifdef UART_RX_BREAK_DET_EN
    assign bus.break_det = break_r;
`else
    assign bus.break_det = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 (depth 4), 8E1 and 8N2 instances share clock, reset and b_tick.
module tb_uart_rx_fifo;
    localparam int BIT_CLKS = 32;   // 16 b_ticks per bit, one b_tick every other clock

    logic clk = 1'b0;
    logic rst;
    logic b_tick;
    logic rx_a, rx_b, rx_c;
    logic rd_a, rd_b, rd_c;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ovr_a = 0;
    int   brk_a = 0;
    int   ovr0, brk0;
    bit   found;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();

    assign if_a.rx = rx_a;  assign if_a.rd_en = rd_a;  assign if_a.b_tick = b_tick;
    assign if_b.rx = rx_b;  assign if_b.rd_en = rd_b;  assign if_b.b_tick = b_tick;
    assign if_c.rx = rx_c;  assign if_c.rd_en = rd_c;  assign if_c.b_tick = b_tick;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    initial begin
        b_tick = 1'b0;
        forever begin
            @(negedge clk);
            b_tick = ~b_tick;
        end
    end

    always @(negedge clk) begin
        if (if_a.overrun)   ovr_a <= ovr_a + 1;
        if (if_a.break_det) brk_a <= brk_a + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rx(input int u, input logic v);
        case (u)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic pop(input int u);
        case (u)
            0:       rd_a = 1'b1;
            1:       rd_b = 1'b1;
            default: rd_c = 1'b1;
        endcase
        @(negedge clk);
        rd_a = 1'b0;
        rd_b = 1'b0;
        rd_c = 1'b0;
    endtask

    // par < 0: no parity bit. A low stop bit is held only 24 clocks so the
    // restarted START detection sees the line high again at its centre.
    task automatic send_frame(input int u, input logic [7:0] d, input int par,
                              input logic [1:0] stops, input int nstop);
        drive_rx(u, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive_rx(u, d[i]);
            wait_clks(BIT_CLKS);
        end
        if (par >= 0) begin
            drive_rx(u, par[0]);
            wait_clks(BIT_CLKS);
        end
        for (int s = 0; s < nstop; s++) begin
            drive_rx(u, stops[s]);
            if (stops[s]) wait_clks(BIT_CLKS);
            else          wait_clks(24);
        end
        drive_rx(u, 1'b1);
        wait_clks(BIT_CLKS);
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);
        check_eq("rst_empty",   if_a.empty,     32'd1);
        check_eq("rst_full",    if_a.full,      32'd0);
        check_eq("rst_level",   if_a.level,     32'd0);
        check_eq("rst_data",    if_a.rd_data,   32'd0);
        check_eq("rst_perr",    if_a.rd_perr,   32'd0);
        check_eq("rst_ferr",    if_a.rd_ferr,   32'd0);
        check_eq("rst_overrun", if_a.overrun,   32'd0);
        check_eq("rst_break",   if_a.break_det, 32'd0);

        // 8N1 single byte
        send_frame(0, 8'hA5, -1, 2'b11, 1);
        check_eq("n1_data",  if_a.rd_data, 32'hA5);
        check_eq("n1_perr",  if_a.rd_perr, 32'd0);
        check_eq("n1_ferr",  if_a.rd_ferr, 32'd0);
        check_eq("n1_level", if_a.level,   32'd1);
        check_eq("n1_empty", if_a.empty,   32'd0);
        pop(0);
        check_eq("n1_pop_level", if_a.level, 32'd0);
        check_eq("n1_pop_empty", if_a.empty, 32'd1);

        // 8E1: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
        send_frame(1, 8'h03, 1, 2'b11, 1);
        check_eq("e1_bad_data", if_b.rd_data, 32'h03);
        check_eq("e1_bad_perr", if_b.rd_perr, 32'd1);
        check_eq("e1_bad_ferr", if_b.rd_ferr, 32'd0);
        pop(1);
        send_frame(1, 8'h03, 0, 2'b11, 1);
        check_eq("e1_ok_data",  if_b.rd_data, 32'h03);
        check_eq("e1_ok_perr",  if_b.rd_perr, 32'd0);
        check_eq("e1_ok_level", if_b.level,   32'd1);
        pop(1);

        // 8N2: second stop bit low
        send_frame(2, 8'h5A, -1, 2'b01, 2);
        check_eq("n2_bad_data",  if_c.rd_data, 32'h5A);
        check_eq("n2_bad_ferr",  if_c.rd_ferr, 32'd1);
        check_eq("n2_bad_level", if_c.level,   32'd1);
        pop(2);
        send_frame(2, 8'h11, -1, 2'b11, 2);
        check_eq("n2_ok_data",  if_c.rd_data, 32'h11);
        check_eq("n2_ok_ferr",  if_c.rd_ferr, 32'd0);
        check_eq("n2_ok_level", if_c.level,   32'd1);
        pop(2);
        check_eq("n2_empty", if_c.empty, 32'd1);

        // fill depth-4 FIFO, fifth byte overruns
        ovr0 = ovr_a;
        for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), -1, 2'b11, 1);
        check_eq("fill_full",  if_a.full,     32'd1);
        check_eq("fill_level", if_a.level,    32'd4);
        check_eq("fill_ovr",   ovr_a - ovr0,  32'd0);
        send_frame(0, 8'h05, -1, 2'b11, 1);
        check_eq("ovr_pulse", ovr_a - ovr0, 32'd1);
        check_eq("ovr_level", if_a.level,   32'd4);
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_data", if_a.rd_data, 32'(k));
            pop(0);
        end
        check_eq("drain_empty", if_a.empty, 32'd1);
        check_eq("drain_full",  if_a.full,  32'd0);

        // pop on the same clock as the push into a full FIFO
        for (int k = 1; k <= 4; k++) send_frame(0, 8'h10 + 8'(k), -1, 2'b11, 1);
        ovr0  = ovr_a;
        found = 1'b0;
        fork
            send_frame(0, 8'h15, -1, 2'b11, 1);
            begin
                for (int t = 0; t < 400 && !found; t++) begin
                    @(negedge clk);
                    #1;
                    if (u_a.push_s) begin
                        rd_a = 1'b1;
                        @(negedge clk);
                        rd_a  = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        check_eq("coinc_push_seen", found,        32'd1);
        check_eq("coinc_ovr",       ovr_a - ovr0, 32'd0);
        check_eq("coinc_level",     if_a.level,   32'd4);
        check_eq("coinc_full",      if_a.full,    32'd1);
        for (int k = 2; k <= 5; k++) begin
            check_eq("coinc_data", if_a.rd_data, 32'h10 + 32'(k));
            pop(0);
        end
        check_eq("coinc_empty", if_a.empty, 32'd1);

        // quarter-bit glitch in IDLE
        rx_a = 1'b0;
        wait_clks(8);
        rx_a = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check_eq("glitch_level", if_a.level, 32'd0);
        check_eq("glitch_empty", if_a.empty, 32'd1);

        // reset in the middle of DATA discards FIFO and partial frame
        send_frame(0, 8'h77, -1, 2'b11, 1);
        check_eq("pre_rst_level", if_a.level, 32'd1);
        rx_a = 1'b0; wait_clks(BIT_CLKS);
        rx_a = 1'b1; wait_clks(BIT_CLKS);
        rx_a = 1'b0; wait_clks(BIT_CLKS);
        rx_a = 1'b1; wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(2);
        check_eq("mid_rst_level", if_a.level,   32'd0);
        check_eq("mid_rst_empty", if_a.empty,   32'd1);
        check_eq("mid_rst_full",  if_a.full,    32'd0);
        check_eq("mid_rst_data",  if_a.rd_data, 32'd0);
        check_eq("mid_rst_ferr",  if_a.rd_ferr, 32'd0);
        send_frame(0, 8'h3C, -1, 2'b11, 1);
        check_eq("post_rst_data",  if_a.rd_data, 32'h3C);
        check_eq("post_rst_ferr",  if_a.rd_ferr, 32'd0);
        check_eq("post_rst_level", if_a.level,   32'd1);
        pop(0);

        // line held low for about two frame times
        brk0 = brk_a;
        rx_a = 1'b0;
        wait_clks(620);
        rx_a = 1'b1;
        wait_clks(2 * BIT_CLKS);
`ifdef UART_RX_BREAK_DET_EN
        check_eq("brk_pulses", brk_a - brk0, 32'd1);
        check_eq("brk_level",  if_a.level,   32'd0);
`else
        check_eq("brk_pulses", brk_a - brk0, 32'd0);
        check_eq("brk_level",  if_a.level,   32'd2);
        for (int k = 0; k < 2; k++) begin
            check_eq("brk_entry_data", if_a.rd_data, 32'd0);
            check_eq("brk_entry_ferr", if_a.rd_ferr, 32'd1);
            pop(0);
        end
        check_eq("brk_empty", if_a.empty, 32'd1);
`endif
        send_frame(0, 8'h7E, -1, 2'b11, 1);
        check_eq("post_brk_data",  if_a.rd_data, 32'h7E);
        check_eq("post_brk_ferr",  if_a.rd_ferr, 32'd0);
        check_eq("post_brk_level", if_a.level,   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
